// File: rtl/vc_ctrl_pkg.sv
// Shared types and constants for the VC arbiter/controller.
// Holds the FSM state encoding, reset thresholds, err_in bit positions and the pipeline stage payload.
package vc_ctrl_pkg;

    localparam int unsigned DATA_W_DEF     = 6;
    localparam int unsigned DEST_BIT_DEF   = 4;
    localparam int unsigned VC0_WEIGHT_DEF = 4;
    localparam int unsigned UMBRAL_W       = 4;
    localparam int unsigned STATE_W        = 3;
    localparam int unsigned ERR_W          = 4;

    // err_in bit positions: {D1, D0, VC1, VC0}
    localparam int unsigned ERR_VC0 = 0;
    localparam int unsigned ERR_VC1 = 1;
    localparam int unsigned ERR_D0  = 2;
    localparam int unsigned ERR_D1  = 3;

    localparam logic [UMBRAL_W-1:0] UMBRAL_VC_RST = '0;
    localparam logic [UMBRAL_W-1:0] UMBRAL_D_RST  = '0;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // First pipeline stage: a read was issued last cycle, and from which VC.
    typedef struct packed {
        logic valid;
        logic src;
    } rd_stage_t;

endpackage

// File: rtl/vc_prio_grant.sv
// VC0-priority grant with a saturating weight counter that forces a VC1 grant
// after WEIGHT consecutive VC0 grants while VC1 is waiting.
module vc_prio_grant #(
    parameter int unsigned WEIGHT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic eligible0,
    input  logic eligible1,
    input  logic pending1,
    input  logic accept,
    output logic gnt0,
    output logic gnt1
);

    localparam int unsigned CNT_W = $clog2(WEIGHT + 1);

    logic [CNT_W-1:0] cnt;
    logic             force1;

    // Combinational grant: VC0 wins unless its weight budget is spent.
    always_comb begin
        force1 = (cnt >= CNT_W'(WEIGHT));
        gnt1   = eligible1 & (~eligible0 | force1);
        gnt0   = eligible0 & ~gnt1;
    end

    // Counts VC0 grants while VC1 waits; clears on a VC1 grant or an empty VC1, saturates at WEIGHT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!pending1 || (accept && gnt1)) begin
            cnt <= '0;
        end else if (accept && gnt0 && (cnt != CNT_W'(WEIGHT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vc_arbiter_ctrl.sv
// Transmit-path scheduler: pops VC0/VC1 FIFOs, routes each word to D0/D1 by one data bit,
// and owns the FIFO threshold configuration. FSM: RESET/INIT/IDLE/ACTIVE/ERROR.
module vc_arbiter_ctrl
    import vc_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEST_BIT   = DEST_BIT_DEF,
    parameter int unsigned VC0_WEIGHT = VC0_WEIGHT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_vc_in,
    input  logic [UMBRAL_W-1:0] umbral_d_in,
    input  logic                empty_vc0,
    input  logic                empty_vc1,
    input  logic                afull_d0,
    input  logic                afull_d1,
    input  logic [ERR_W-1:0]    err_in,
    input  logic [DATA_W-1:0]   data_vc0,
    input  logic [DATA_W-1:0]   data_vc1,
    output logic                rd_vc0,
    output logic                rd_vc1,
    output logic                wr_d0,
    output logic                wr_d1,
    output logic [DATA_W-1:0]   data_out,
    output logic [UMBRAL_W-1:0] umbral_vc,
    output logic [UMBRAL_W-1:0] umbral_d,
    output logic [STATE_W-1:0]  state,
    output logic                idle,
    output logic                error_out
);

    state_t            st;
    state_t            st_nx;
    rd_stage_t         stg1;
    logic              err_any;
    logic              issue_ok;
    logic              kill;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] word;

    always_comb begin
        err_any = err_in[ERR_VC0] | err_in[ERR_VC1] | err_in[ERR_D0] | err_in[ERR_D1];
    end

    // Next state and read-issue permission; ERROR outranks every other transition.
    always_comb begin
        st_nx    = st;
        issue_ok = 1'b0;
        case (st)
            ST_RESET: st_nx = ST_INIT;
            ST_INIT: begin
                if (err_any)    st_nx = ST_ERROR;
                else if (!init) st_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (err_any)                      st_nx = ST_ERROR;
                else if (init)                    st_nx = ST_INIT;
                else if (!empty_vc0 || !empty_vc1) st_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (err_any) begin
                    st_nx = ST_ERROR;
                end else if (init) begin
                    st_nx = ST_INIT;
                end else begin
                    // Destination is unknown before data returns, so both D FIFOs must have room.
                    issue_ok = reset & ~afull_d0 & ~afull_d1;
                    if (empty_vc0 && empty_vc1 && !stg1.valid) st_nx = ST_IDLE;
                end
            end
            ST_ERROR: st_nx = ST_ERROR;
            default:  st_nx = ST_RESET;
        endcase
    end

    always_comb begin
        kill = (st == ST_ERROR) ||
               (err_any && ((st == ST_INIT) || (st == ST_IDLE) || (st == ST_ACTIVE)));
    end

    vc_prio_grant #(
        .WEIGHT(VC0_WEIGHT)
    ) u_grant (
        .clk      (clk),
        .reset    (reset),
        .eligible0(~empty_vc0),
        .eligible1(~empty_vc1),
        .pending1 (~empty_vc1),
        .accept   (issue_ok),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    assign rd_vc0 = issue_ok & gnt0;
    assign rd_vc1 = issue_ok & gnt1;

    // State register plus registered state decodes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st        <= ST_RESET;
            idle      <= 1'b0;
            error_out <= 1'b0;
        end else begin
            st        <= st_nx;
            idle      <= (st_nx == ST_IDLE);
            error_out <= (st_nx == ST_ERROR);
        end
    end

    assign state = st;

    always_ff @(posedge clk) begin
        if (!reset) begin
            umbral_vc <= UMBRAL_VC_RST;
            umbral_d  <= UMBRAL_D_RST;
        end else if ((st == ST_INIT) && init) begin
            umbral_vc <= umbral_vc_in;
            umbral_d  <= umbral_d_in;
        end
    end

    always_comb begin
        word = stg1.src ? data_vc1 : data_vc0;
    end

    // Two-stage pipeline: stage 1 remembers the read, stage 2 captures data and steers the write.
    always_ff @(posedge clk) begin
        if (!reset || kill) begin
            stg1     <= '0;
            data_out <= '0;
            wr_d0    <= 1'b0;
            wr_d1    <= 1'b0;
        end else begin
            stg1.valid <= rd_vc0 | rd_vc1;
            stg1.src   <= rd_vc1;
            data_out   <= stg1.valid ? word : '0;
            wr_d0      <= stg1.valid & ~word[DEST_BIT];
            wr_d1      <= stg1.valid & word[DEST_BIT];
        end
    end

endmodule
